// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan controller for a 6-digit hex 7-segment display.
// Double-buffered value, blanking gap per slot, per-digit masking and leading-zero suppression.
module seg7_scan_driver #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] disp_in,
    input  logic [5:0]  blank_mask,
    input  logic        lz_supp,
    output logic [2:0]  scan_idx,
    output logic [3:0]  digit,
    output logic [5:0]  an,
    output logic        digit_valid,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ON_START = CW'(BLANK_CYC);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    idx_s;
    logic [23:0]   pending_r, pending_s;
    logic [23:0]   active_r, active_s;
    logic [3:0]    digit_s;
    logic [5:0]    an_s;
    logic          frame_done_s;
    logic          boundary_s;

    function automatic logic [3:0] nibble_at(input logic [23:0] val, input logic [2:0] idx);
        case (idx)
            3'd0:    nibble_at = val[3:0];
            3'd1:    nibble_at = val[7:4];
            3'd2:    nibble_at = val[11:8];
            3'd3:    nibble_at = val[15:12];
            3'd4:    nibble_at = val[19:16];
            3'd5:    nibble_at = val[23:20];
            default: nibble_at = 4'h0;
        endcase
    endfunction

    // Physical anode wiring is not in index order: digit 0 is bit 0, the rest run down from bit 5.
    function automatic logic [5:0] anode_map(input logic [2:0] idx);
        case (idx)
            3'd0:    anode_map = 6'b000001;
            3'd1:    anode_map = 6'b100000;
            3'd2:    anode_map = 6'b010000;
            3'd3:    anode_map = 6'b001000;
            3'd4:    anode_map = 6'b000100;
            3'd5:    anode_map = 6'b000010;
            default: anode_map = 6'b000000;
        endcase
    endfunction

    function automatic logic is_dark(input logic [23:0] val, input logic [2:0] idx,
                                     input logic [5:0] mask, input logic lz);
        logic masked;
        logic upper_nz;
        case (idx)
            3'd0:    masked = mask[0];
            3'd1:    masked = mask[1];
            3'd2:    masked = mask[2];
            3'd3:    masked = mask[3];
            3'd4:    masked = mask[4];
            3'd5:    masked = mask[5];
            default: masked = 1'b1;
        endcase
        upper_nz = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if ((k >= int'(idx)) && (val[4*k +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end else begin
                upper_nz = upper_nz;
            end
        end
        is_dark = masked || (lz && (idx != 3'd0) && !upper_nz);
    endfunction

    // Next-state and next-output computation; all outputs are registered from these values.
    always_comb begin
        cnt_s        = cnt_r;
        idx_s        = scan_idx;
        state_s      = state_r;
        an_s         = 6'b000000;
        frame_done_s = 1'b0;

        boundary_s = (state_r == ST_ON) && (cnt_r == CNT_LAST) && (scan_idx == 3'd5);
        pending_s  = load ? disp_in : pending_r;
        active_s   = boundary_s ? pending_s : active_r;

        if (cnt_r == CNT_LAST) begin
            cnt_s = {CW{1'b0}};
            idx_s = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            cnt_s = cnt_r + CW'(1);
            idx_s = scan_idx;
        end

        case (state_r)
            ST_BLANK: state_s = (cnt_s >= ON_START) ? ST_ON : ST_BLANK;
            ST_ON:    state_s = (cnt_s >= ON_START) ? ST_ON : ST_BLANK;
            default:  state_s = ST_BLANK;
        endcase

        digit_s = nibble_at(active_s, idx_s);

        if ((state_s == ST_ON) && !is_dark(active_s, idx_s, blank_mask, lz_supp)) begin
            an_s = anode_map(idx_s);
        end else begin
            an_s = 6'b000000;
        end

        if ((state_s == ST_ON) && (cnt_s == CNT_LAST) && (idx_s == 3'd5)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_BLANK;
            cnt_r       <= {CW{1'b0}};
            pending_r   <= 24'h000000;
            active_r    <= 24'h000000;
            scan_idx    <= 3'd0;
            digit       <= 4'h0;
            an          <= 6'b000000;
            digit_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pending_r   <= pending_s;
            active_r    <= active_s;
            scan_idx    <= idx_s;
            digit       <= digit_s;
            an          <= an_s;
            digit_valid <= |an_s;
            frame_done  <= frame_done_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-based reference model
// (slot and phase derived from elapsed cycles since reset).
module tb_seg7_scan_driver;

    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FRAME = 6 * CD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [23:0] disp_in;
    logic [5:0]  blank_mask;
    logic        lz_supp;
    logic [2:0]  scan_idx;
    logic [3:0]  digit;
    logic [5:0]  an;
    logic        digit_valid;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          t = 0;
    logic [23:0] pend_m = 24'h0;
    logic [23:0] act_m = 24'h0;
    logic [5:0]  amap [6] = '{6'b000001, 6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010};

    seg7_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .load(load), .disp_in(disp_in),
        .blank_mask(blank_mask), .lz_supp(lz_supp), .scan_idx(scan_idx),
        .digit(digit), .an(an), .digit_valid(digit_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp_v);
        end
    endtask

    // One clock: advance the model on the edge, then compare on the falling edge.
    task automatic step();
        int   slot;
        int   phase;
        logic lit;
        logic [5:0] exp_an;
        @(posedge clk);
        if (rst) begin
            t = 0;
            pend_m = 24'h0;
            act_m = 24'h0;
        end else begin
            t = t + 1;
            if (load) pend_m = disp_in;
            if (t % FRAME == 0) act_m = pend_m;
        end
        @(negedge clk);
        slot  = (t / CD) % 6;
        phase = t % CD;
        lit = !blank_mask[slot] && (!lz_supp || slot == 0 || ((act_m >> (4 * slot)) != 24'h0));
        exp_an = (phase >= BC && lit) ? amap[slot] : 6'b000000;
        check_eq("scan_idx", 32'(scan_idx), 32'(slot));
        check_eq("digit", 32'(digit), 32'((act_m >> (4 * slot)) & 24'hF));
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("digit_valid", 32'(digit_valid), 32'(exp_an != 6'b000000));
        check_eq("frame_done", 32'(frame_done), 32'(slot == 5 && phase == CD - 1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [23:0] v);
        disp_in = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_for(input int slot, input int phase);
        int guard = 0;
        while (!(((t / CD) % 6 == slot) && (t % CD == phase)) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; disp_in = 24'h0; blank_mask = 6'b0; lz_supp = 1'b0;
        run(3);
        rst = 1'b0;
        run(5);
        pulse_load(24'h123456);
        run(2 * FRAME);
        wait_for(2, 4);
        pulse_load(24'hABCDEF);
        run(2 * FRAME);
        lz_supp = 1'b1;
        pulse_load(24'h000042);
        run(2 * FRAME);
        pulse_load(24'h000000);
        run(2 * FRAME);
        lz_supp = 1'b0;
        blank_mask = 6'b100001;
        pulse_load(24'h123456);
        run(2 * FRAME);
        blank_mask = 6'b000000;
        wait_for(5, CD - 1);
        pulse_load(24'h00FF00);
        run(FRAME + 4);
        wait_for(3, BC + 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(FRAME);
        for (int i = 0; i < 2500; i++) begin
            load = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: disp_in = 24'($urandom);
                1: disp_in = 24'($urandom) & 24'h0000FF;
                2: disp_in = 24'($urandom) & 24'h00F0F0;
                default: disp_in = 24'h000000;
            endcase
            if ($urandom_range(0, 199) == 0) blank_mask = 6'($urandom);
            if ($urandom_range(0, 99) == 0) lz_supp = ~lz_supp;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
